// File: rtl/vslide_xlane_if.sv
// Lane ext interface between the cross-lane slide unit and the lane array.
// The unit (master) broadcasts read/write slot indices and per-lane write
// strobes/data; the lanes (slave) return vs2 read data for the read slot.
//   vs_elem_cnt  unit -> lanes  read slot index
//   vs2_rdata    lanes -> unit  lane L data at [L*DATA_WIDTH +: DATA_WIDTH]
//   vd_elem_cnt  unit -> lanes  write slot index
//   vd_wr_en     unit -> lanes  per-lane write enable
//   vd_wdata     unit -> lanes  per-lane write data
interface vslide_xlane_if #(
  parameter int DATA_WIDTH = 32,
  parameter int LANES      = 4,
  parameter int CNT_B      = 2
);
  logic [CNT_B-1:0]            vs_elem_cnt;
  logic [LANES*DATA_WIDTH-1:0] vs2_rdata;
  logic [CNT_B-1:0]            vd_elem_cnt;
  logic [LANES-1:0]            vd_wr_en;
  logic [LANES*DATA_WIDTH-1:0] vd_wdata;

  modport master (
    output vs_elem_cnt, vd_elem_cnt, vd_wr_en, vd_wdata,
    input  vs2_rdata
  );

  modport slave (
    input  vs_elem_cnt, vd_elem_cnt, vd_wr_en, vd_wdata,
    output vs2_rdata
  );
endinterface

// File: rtl/vslide_xlane_unit.sv
// Cross-lane slide engine (vslideup / vslidedown). Gathers all vs2 elements
// from the lanes into a local buffer one slot per cycle, then scatters the
// permuted elements back one slot per cycle. Element i lives in lane
// i % LANES, slot i / LANES.
// Ports:
//   clk_i, resetn_i      clock, async active-low reset
//   start_i              start request, sampled only when idle
//   dir_i                0 = slide up, 1 = slide down
//   offset_i             unsigned slide amount (full width compared)
//   vl_i, vm_i, mask_i   active length, unmasked flag, per-element mask
//   busy_o, done_o       operation in progress / one-cycle completion pulse
//   ext                  lane ext interface (master side)
//
// state    | meaning
// ---------+-----------------------------------------------------------
// IDLE     | waiting for start_i; operands latched on acceptance
// GATHER   | presenting read slots 0..ELEMS-1 to the lanes
// DRAIN    | RD_LAT cycles waiting for the last slot's data to arrive
// SCATTER  | writing destination slots 0..ELEMS-1
// DONE     | done_o pulse, busy_o low; back to IDLE
module vslide_xlane_unit #(
  parameter int  DATA_WIDTH = 32,
  parameter int  VLEN       = 512,
  parameter int  LANES      = 4,
  parameter int  RD_LAT     = 2,
  localparam int ELEMS      = VLEN / (LANES * DATA_WIDTH),
  localparam int N          = LANES * ELEMS,
  localparam int CNT_B      = $clog2(ELEMS),
  localparam int NB         = $clog2(N) + 1
) (
  input  logic                  clk_i,
  input  logic                  resetn_i,
  input  logic                  start_i,
  input  logic                  dir_i,
  input  logic [DATA_WIDTH-1:0] offset_i,
  input  logic [NB-1:0]         vl_i,
  input  logic                  vm_i,
  input  logic [N-1:0]          mask_i,
  output logic                  busy_o,
  output logic                  done_o,
  vslide_xlane_if.master        ext
);

  localparam int IDX_B = $clog2(N);
  localparam int DR_B  = $clog2(RD_LAT + 1);
  localparam logic [CNT_B-1:0] LAST_SLOT = CNT_B'(ELEMS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_GATHER,
    S_DRAIN,
    S_SCATTER,
    S_DONE
  } state_t;

  state_t state_q, state_d;

  logic [CNT_B-1:0]      slot_q;
  logic [DR_B-1:0]       drain_q;

  logic                  dir_q;
  logic                  vm_q;
  logic [DATA_WIDTH-1:0] off_q;
  logic [NB-1:0]         vl_q;
  logic [N-1:0]          mask_q;

  // Tracks which read slot the lane data on vs2_rdata belongs to.
  logic [RD_LAT-1:0]             cap_vld_q;
  logic [RD_LAT-1:0][CNT_B-1:0]  cap_slot_q;

  logic [DATA_WIDTH-1:0] elem_buf [N];

  logic [LANES-1:0]            wr_en;
  logic [LANES*DATA_WIDTH-1:0] wdata;

  always_ff @(posedge clk_i or negedge resetn_i) begin
    if (!resetn_i) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:    if (start_i) state_d = S_GATHER;
      S_GATHER:  if (slot_q == LAST_SLOT) state_d = S_DRAIN;
      S_DRAIN:   if (drain_q == '0) state_d = S_SCATTER;
      S_SCATTER: if (slot_q == LAST_SLOT) state_d = S_DONE;
      S_DONE:    state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
  end

  // Slot counter restarts at 0 on every state change so GATHER and SCATTER
  // both begin at slot 0. Drain timer is a down-counter loaded during GATHER.
  always_ff @(posedge clk_i or negedge resetn_i) begin
    if (!resetn_i) begin
      slot_q  <= '0;
      drain_q <= '0;
    end else begin
      if (state_d != state_q) begin
        slot_q <= '0;
      end else if (state_q == S_GATHER || state_q == S_SCATTER) begin
        slot_q <= slot_q + CNT_B'(1);
      end

      if (state_q == S_GATHER) begin
        drain_q <= DR_B'(RD_LAT - 1);
      end else if (state_q == S_DRAIN && drain_q != '0) begin
        drain_q <= drain_q - DR_B'(1);
      end
    end
  end

  always_ff @(posedge clk_i or negedge resetn_i) begin
    if (!resetn_i) begin
      dir_q  <= 1'b0;
      vm_q   <= 1'b0;
      off_q  <= '0;
      vl_q   <= '0;
      mask_q <= '0;
    end else if (state_q == S_IDLE && start_i) begin
      dir_q  <= dir_i;
      vm_q   <= vm_i;
      off_q  <= offset_i;
      vl_q   <= vl_i;
      mask_q <= mask_i;
    end
  end

  always_ff @(posedge clk_i or negedge resetn_i) begin
    if (!resetn_i) begin
      cap_vld_q  <= '0;
      cap_slot_q <= '0;
    end else begin
      cap_vld_q[0]  <= (state_q == S_GATHER);
      cap_slot_q[0] <= slot_q;
      for (int k = 1; k < RD_LAT; k++) begin
        cap_vld_q[k]  <= cap_vld_q[k-1];
        cap_slot_q[k] <= cap_slot_q[k-1];
      end
    end
  end

  // Buffer content is don't-care after reset, so it carries no reset.
  always_ff @(posedge clk_i) begin
    if (cap_vld_q[RD_LAT-1]) begin
      for (int l = 0; l < LANES; l++) begin
        elem_buf[IDX_B'(cap_slot_q[RD_LAT-1]) * IDX_B'(LANES) + IDX_B'(l)]
          <= ext.vs2_rdata[l*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  // Destination element i = slot*LANES + lane. The down-slide source sum is
  // one bit wider than the offset so a huge offset never wraps into range.
  always_comb begin
    logic [IDX_B-1:0]    idx;
    logic [IDX_B-1:0]    src;
    logic                act;
    logic                hit;
    logic [DATA_WIDTH:0] sum;
    idx   = '0;
    src   = '0;
    act   = 1'b0;
    hit   = 1'b0;
    sum   = '0;
    wr_en = '0;
    wdata = '0;
    for (int l = 0; l < LANES; l++) begin
      idx = IDX_B'(slot_q) * IDX_B'(LANES) + IDX_B'(l);
      act = (NB'(idx) < vl_q) && (vm_q || mask_q[idx]);
      sum = {1'b0, off_q} + (DATA_WIDTH+1)'(idx);
      if (dir_q) begin
        hit = act;
        src = sum[IDX_B-1:0];
      end else begin
        hit = act && (DATA_WIDTH'(idx) >= off_q);
        src = idx - off_q[IDX_B-1:0];
      end
      if (state_q == S_SCATTER && hit) begin
        wr_en[l] = 1'b1;
        if (!dir_q || sum < (DATA_WIDTH+1)'(N)) begin
          wdata[l*DATA_WIDTH +: DATA_WIDTH] = elem_buf[src];
        end
      end
    end
  end

  assign busy_o = (state_q == S_GATHER) || (state_q == S_DRAIN) ||
                  (state_q == S_SCATTER);
  assign done_o = (state_q == S_DONE);

  assign ext.vs_elem_cnt = (state_q == S_GATHER)  ? slot_q : '0;
  assign ext.vd_elem_cnt = (state_q == S_SCATTER) ? slot_q : '0;
  assign ext.vd_wr_en    = wr_en;
  assign ext.vd_wdata    = wdata;

endmodule

// File: tb/tb_vslide_xlane_unit.sv
// Bench for vslide_xlane_unit: lane read model with RD_LAT latency, a
// timeline/arithmetic reference model checked every cycle, directed literal
// expectations, and randomized operations.
module tb_vslide_xlane_unit;
  localparam int DW     = 32;
  localparam int VLEN   = 512;
  localparam int LANES  = 4;
  localparam int RD_LAT = 2;
  localparam int ELEMS  = VLEN / (LANES * DW);
  localparam int N      = LANES * ELEMS;
  localparam int CNT_B  = $clog2(ELEMS);
  localparam int NB     = $clog2(N) + 1;
  localparam int LAT    = 2 * ELEMS + RD_LAT + 1;

  logic          clk_i    = 1'b0;
  logic          resetn_i = 1'b1;
  logic          start_i  = 1'b0;
  logic          dir_i    = 1'b0;
  logic [DW-1:0] offset_i = '0;
  logic [NB-1:0] vl_i     = '0;
  logic          vm_i     = 1'b0;
  logic [N-1:0]  mask_i   = '0;
  logic          busy_o;
  logic          done_o;

  vslide_xlane_if #(.DATA_WIDTH(DW), .LANES(LANES), .CNT_B(CNT_B)) ext_if ();

  vslide_xlane_unit #(.DATA_WIDTH(DW), .VLEN(VLEN), .LANES(LANES), .RD_LAT(RD_LAT)) dut (
    .clk_i    (clk_i),
    .resetn_i (resetn_i),
    .start_i  (start_i),
    .dir_i    (dir_i),
    .offset_i (offset_i),
    .vl_i     (vl_i),
    .vm_i     (vm_i),
    .mask_i   (mask_i),
    .busy_o   (busy_o),
    .done_o   (done_o),
    .ext      (ext_if)
  );

  always #5 clk_i = ~clk_i;

  int checks = 0;
  int errors = 0;
  int edges  = 0;
  int e0     = 0;

  logic [DW-1:0]    vs2 [N];
  logic [CNT_B-1:0] rd_pipe [RD_LAT];

  // Lane array: data for the slot presented RD_LAT cycles ago.
  always @(posedge clk_i) begin
    rd_pipe[0] <= ext_if.vs_elem_cnt;
    for (int k = 1; k < RD_LAT; k++) rd_pipe[k] <= rd_pipe[k-1];
  end

  always_comb begin
    ext_if.vs2_rdata = '0;
    for (int l = 0; l < LANES; l++)
      ext_if.vs2_rdata[l*DW +: DW] = vs2[int'(rd_pipe[RD_LAT-1]) * LANES + l];
  end

  always @(posedge clk_i) edges <= edges + 1;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic bit model_en(input int i);
    bit act;
    longint unsigned off, ii;
    act = (i < int'(vl_i)) && (vm_i || mask_i[i]);
    off = longint'(offset_i);
    ii  = longint'(i);
    if (!dir_i) return act && (off <= ii);
    return act;
  endfunction

  function automatic logic [DW-1:0] model_dat(input int i);
    longint unsigned off, ii;
    off = longint'(offset_i);
    ii  = longint'(i);
    if (!model_en(i)) return '0;
    if (!dir_i) return vs2[i - int'(off)];
    if (off + ii < N) return vs2[int'(off + ii)];
    return '0;
  endfunction

  // t = cycles since the accepting edge (-1 when idle).
  int            t = -1;
  bit            m_en  [N];
  logic [DW-1:0] m_dat [N];

  always @(posedge clk_i or negedge resetn_i) begin
    if (!resetn_i) begin
      t <= -1;
    end else if (t < 0) begin
      if (start_i) begin
        t <= 0;
        for (int i = 0; i < N; i++) begin
          m_en[i]  <= model_en(i);
          m_dat[i] <= model_dat(i);
        end
      end
    end else if (t == LAT - 1) begin
      t <= -1;
    end else begin
      t <= t + 1;
    end
  end

  task automatic compare_cycle();
    int  s;
    int  idx;
    bit  scat;
    bit  en;
    s    = t - (ELEMS + RD_LAT);
    scat = (t >= 0) && (s >= 0) && (s < ELEMS);
    chk("busy", busy_o, (t >= 0 && t < LAT - 1) ? 1 : 0);
    chk("done", done_o, (t == LAT - 1) ? 1 : 0);
    chk("vs_elem_cnt", ext_if.vs_elem_cnt, (t >= 0 && t < ELEMS) ? t : 0);
    chk("vd_elem_cnt", ext_if.vd_elem_cnt, scat ? s : 0);
    for (int l = 0; l < LANES; l++) begin
      idx = scat ? s * LANES + l : 0;
      en  = scat && m_en[idx];
      chk($sformatf("wr_en[%0d]", l), ext_if.vd_wr_en[l], en);
      chk($sformatf("wdata[%0d]", l), ext_if.vd_wdata[l*DW +: DW], en ? m_dat[idx] : 0);
    end
  endtask

  always @(negedge clk_i) compare_cycle();

  // ---------------- write monitor ----------------
  bit            obs_en  [N];
  logic [DW-1:0] obs_dat [N];
  int            wr_cnt = 0;

  task automatic monitor_cycle();
    int idx;
    for (int l = 0; l < LANES; l++) begin
      if (ext_if.vd_wr_en[l]) begin
        idx          = int'(ext_if.vd_elem_cnt) * LANES + l;
        obs_en[idx]  = 1'b1;
        obs_dat[idx] = ext_if.vd_wdata[l*DW +: DW];
        wr_cnt++;
      end
    end
  endtask

  always @(negedge clk_i) monitor_cycle();

  task automatic clear_obs();
    for (int i = 0; i < N; i++) begin
      obs_en[i]  = 1'b0;
      obs_dat[i] = '0;
    end
    wr_cnt = 0;
  endtask

  task automatic start_op(input bit d, input logic [DW-1:0] off, input int vl,
                          input bit vm, input logic [N-1:0] m, input bit hold);
    @(posedge clk_i); #2;
    dir_i    = d;
    offset_i = off;
    vl_i     = NB'(vl);
    vm_i     = vm;
    mask_i   = m;
    start_i  = 1'b1;
    clear_obs();
    @(posedge clk_i); #1;
    e0 = edges;
    if (!hold) start_i = 1'b0;
  endtask

  // Latency is counted to the clock edge that samples done_o high.
  task automatic wait_done(output int lat);
    bit seen;
    seen = 1'b0;
    lat  = -1;
    for (int n = 0; n < 40 && !seen; n++) begin
      @(negedge clk_i);
      if (done_o) begin
        seen = 1'b1;
        lat  = edges - e0 + 1;
      end
    end
    chk("done_seen", seen, 1);
  endtask

  task automatic fill_ramp();
    for (int i = 0; i < N; i++) vs2[i] = DW'(i + 100);
  endtask

  initial begin
    int lat;
    int sel;
    logic [DW-1:0] off;
    longint zor;

    for (int i = 0; i < N; i++) vs2[i] = '0;
    #3 resetn_i = 1'b0;
    #1;
    chk("reset_busy", busy_o, 0);
    chk("reset_done", done_o, 0);
    chk("reset_wr_en", ext_if.vd_wr_en, 0);
    chk("reset_vs_cnt", ext_if.vs_elem_cnt, 0);
    repeat (3) @(posedge clk_i);
    #2 resetn_i = 1'b1;

    // slide up by 3
    fill_ramp();
    start_op(1'b0, 32'd3, 16, 1'b1, '0, 1'b0);
    wait_done(lat);
    chk("up3_latency", lat, 11);
    chk("up3_writes", wr_cnt, 13);
    chk("up3_en2", obs_en[2], 0);
    chk("up3_d3", obs_dat[3], 100);
    chk("up3_d15", obs_dat[15], 112);

    // slide down by 5
    start_op(1'b1, 32'd5, 16, 1'b1, '0, 1'b0);
    wait_done(lat);
    chk("dn5_writes", wr_cnt, 16);
    chk("dn5_d0", obs_dat[0], 105);
    chk("dn5_d10", obs_dat[10], 115);
    chk("dn5_en11", obs_en[11], 1);
    chk("dn5_d11", obs_dat[11], 0);

    // mask and vl
    start_op(1'b1, 32'd1, 6, 1'b0, 16'h00FF, 1'b0);
    wait_done(lat);
    chk("mask_writes", wr_cnt, 6);
    chk("mask_d5", obs_dat[5], 106);
    chk("mask_en6", obs_en[6], 0);

    // huge offset, down then up
    start_op(1'b1, 32'hFFFF_FFFF, 16, 1'b1, '0, 1'b0);
    wait_done(lat);
    zor = 0;
    for (int i = 0; i < N; i++) zor = zor | longint'(obs_dat[i]);
    chk("bigdn_writes", wr_cnt, 16);
    chk("bigdn_data_or", zor, 0);
    start_op(1'b0, 32'hFFFF_FFFF, 16, 1'b1, '0, 1'b0);
    wait_done(lat);
    chk("bigup_writes", wr_cnt, 0);
    chk("bigup_latency", lat, 11);

    // vl = 0
    start_op(1'b0, 32'd0, 0, 1'b1, '1, 1'b0);
    wait_done(lat);
    chk("vl0_writes", wr_cnt, 0);
    chk("vl0_latency", lat, 11);

    // start held high; operands changed while busy must not matter
    start_op(1'b1, 32'd2, 16, 1'b1, '0, 1'b1);
    offset_i = 32'd7;
    wait_done(lat);
    chk("hold1_latency", lat, 11);
    chk("hold1_busy_at_done", busy_o, 0);
    chk("hold1_d0", obs_dat[0], 102);
    @(posedge clk_i); #1;
    chk("hold_not_queued", busy_o, 0);
    clear_obs();
    @(posedge clk_i); #1;
    chk("hold_second_accept", busy_o, 1);
    e0 = edges;
    start_i = 1'b0;
    wait_done(lat);
    chk("hold2_latency", lat, 11);
    chk("hold2_d0", obs_dat[0], 107);
    chk("hold2_d8", obs_dat[8], 115);
    chk("hold2_en9", obs_en[9], 1);
    chk("hold2_d9", obs_dat[9], 0);

    // reset during scatter slot 1
    start_op(1'b1, 32'd0, 16, 1'b1, '0, 1'b0);
    repeat (ELEMS + RD_LAT + 1) @(posedge clk_i);
    #2;
    chk("pre_reset_slot", ext_if.vd_elem_cnt, 1);
    resetn_i = 1'b0;
    #1;
    chk("rst_busy", busy_o, 0);
    chk("rst_wr_en", ext_if.vd_wr_en, 0);
    chk("rst_wdata_nz", (ext_if.vd_wdata != '0) ? 1 : 0, 0);
    chk("rst_vd_cnt", ext_if.vd_elem_cnt, 0);
    wr_cnt = 0;
    repeat (2) @(posedge clk_i);
    #2 resetn_i = 1'b1;
    repeat (6) @(negedge clk_i);
    chk("no_writes_after_reset", wr_cnt, 0);
    start_op(1'b0, 32'd1, 16, 1'b1, '0, 1'b0);
    wait_done(lat);
    chk("post_reset_latency", lat, 11);
    chk("post_reset_d1", obs_dat[1], 100);

    // randomized operations, checked cycle by cycle by the model
    for (int n = 0; n < 40; n++) begin
      for (int i = 0; i < N; i++) vs2[i] = $urandom;
      sel = $urandom_range(0, 3);
      case (sel)
        0: off = DW'($urandom_range(0, N + 2));
        1: off = $urandom;
        2: off = 32'hFFFF_FFFF - DW'($urandom_range(0, 3));
        default: off = DW'($urandom_range(0, N - 1));
      endcase
      start_op(1'($urandom_range(0, 1)), off, $urandom_range(0, N),
               1'($urandom_range(0, 1)), N'($urandom), 1'b0);
      wait_done(lat);
      chk("rand_latency", lat, LAT);
      repeat ($urandom_range(0, 2)) @(posedge clk_i);
    end

    repeat (3) @(posedge clk_i);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

endmodule
